// File: rtl/deser_pkg.sv
// Shared definitions for the 1:10 DDR deserializer.
//   state_t   : alignment FSM encoding (HUNT, VERIFY, LOCKED)
//   PAIR_W    : bits captured per fast clock by the input DDR flop
//   WORD_W    : width of one 8b/10b symbol
//   HIST_W    : width of the bit history (two words)
//   K28_5_RDN : comma symbol, running disparity negative, bit 0 first on the line
//   K28_5_RDP : comma symbol, running disparity positive (bitwise complement)
package deser_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int PAIR_W = 2;
  localparam int WORD_W = 10;
  localparam int HIST_W = 2 * WORD_W;

  localparam logic [WORD_W-1:0] K28_5_RDN = 10'b0101111100;
  localparam logic [WORD_W-1:0] K28_5_RDP = 10'b1010000011;

endpackage

// File: rtl/comma_detect.sv
// Parallel comma comparators over every 10-bit window of the bit history.
//   hist      : 20-bit history, bit 0 oldest
//   match     : match[k] set when hist[k+9:k] equals COMMA or ~COMMA
//   any_match : at least one window matches
//   first_idx : lowest matching window index (0 when none match)
module comma_detect
  import deser_pkg::*;
#(
  parameter logic [WORD_W-1:0] COMMA = K28_5_RDN
) (
  input  logic [HIST_W-1:0] hist,
  output logic [WORD_W-1:0] match,
  output logic              any_match,
  output logic [3:0]        first_idx
);

  always_comb begin
    match = '0;
    for (int k = 0; k < WORD_W; k++) begin
      // Either disparity of the comma counts as one hit.
      match[k] = (hist[k +: WORD_W] == COMMA) || (hist[k +: WORD_W] == ~COMMA);
    end
  end

  assign any_match = |match;

  always_comb begin
    first_idx = 4'd0;
    // Scan downwards so the lowest matching index wins.
    for (int k = WORD_W - 1; k >= 0; k--) begin
      if (match[k]) first_idx = 4'(k);
    end
  end

endmodule

// File: rtl/deserializer_ddr_1_to_10.sv
// 1:10 DDR deserializer with comma-based word alignment, fast clock domain only.
//   fast_clk_i  : bit-pair clock (line rate / 2)
//   rst         : synchronous active-high reset
//   ddr_i       : captured pair, [0] earlier bit, [1] later bit
//   dat_o       : aligned word, bit 0 first on the line
//   dat_valid_o : one-cycle strobe every 5 clocks, dat_o is new
//   comma_o     : word on dat_o is COMMA or ~COMMA (qualifies dat_valid_o)
//   locked_o    : alignment locked
//   align_off_o : current bit offset 0..9
//   fsm_state   : alignment FSM state, for observation
// Handshake: dat_valid_o is a pure strobe with no back-pressure; the consumer
// must take dat_o/comma_o in the cycle dat_valid_o is high.
module deserializer_ddr_1_to_10
  import deser_pkg::*;
#(
  parameter bit                INVERT       = 1'b1,
  parameter logic [WORD_W-1:0] COMMA        = K28_5_RDN,
  parameter int                LOCK_CNT     = 4,
  parameter int                COMMA_WINDOW = 32
) (
  input  logic              fast_clk_i,
  input  logic              rst,
  input  logic [PAIR_W-1:0] ddr_i,
  output logic [WORD_W-1:0] dat_o,
  output logic              dat_valid_o,
  output logic              comma_o,
  output logic              locked_o,
  output logic [3:0]        align_off_o,
  output logic [1:0]        fsm_state
);

  localparam logic [3:0] HITS_LAST = 4'(LOCK_CNT - 1);
  localparam logic [3:0] HITS_MAX  = 4'(LOCK_CNT);
  localparam logic [7:0] MISS_LAST = 8'(COMMA_WINDOW - 1);
  localparam logic [7:0] MISS_MAX  = 8'(COMMA_WINDOW);

  logic [PAIR_W-1:0] bits;
  logic [HIST_W-1:0] hist;
  logic [2:0]        slot;
  logic              strobe;
  logic [WORD_W-1:0] match;
  logic              any_match;
  logic [3:0]        first_idx;
  logic [WORD_W-1:0] word_sel;

  state_t     state, state_nxt;
  logic [3:0] off, off_nxt;
  logic [3:0] hits, hits_nxt;
  logic [7:0] miss, miss_nxt;

  assign bits = INVERT ? ~ddr_i : ddr_i;

  // Newest pair enters at the top, so hist[0] is the oldest bit.
  always_ff @(posedge fast_clk_i) begin
    if (rst) hist <= '0;
    else     hist <= {bits, hist[HIST_W-1:PAIR_W]};
  end

  always_ff @(posedge fast_clk_i) begin
    if (rst)              slot <= 3'd0;
    else if (slot == 3'd4) slot <= 3'd0;
    else                   slot <= slot + 3'd1;
  end

  assign strobe   = (slot == 3'd4);
  assign word_sel = hist[{1'b0, off} +: WORD_W];

  comma_detect #(
    .COMMA (COMMA)
  ) u_comma_detect (
    .hist      (hist),
    .match     (match),
    .any_match (any_match),
    .first_idx (first_idx)
  );

  always_comb begin
    state_nxt = state;
    off_nxt   = off;
    hits_nxt  = hits;
    miss_nxt  = miss;
    if (strobe) begin
      case (state)
        HUNT: begin
          if (any_match) begin
            off_nxt   = first_idx;
            hits_nxt  = 4'd1;
            miss_nxt  = 8'd0;
            state_nxt = VERIFY;
          end
        end
        VERIFY: begin
          if (match[off]) begin
            miss_nxt = 8'd0;
            if (hits >= HITS_LAST) begin
              hits_nxt  = HITS_MAX;
              state_nxt = LOCKED;
            end else begin
              hits_nxt = hits + 4'd1;
            end
          end else if (miss >= MISS_LAST) begin
            miss_nxt  = MISS_MAX;
            state_nxt = HUNT;
          end else begin
            miss_nxt = miss + 8'd1;
          end
        end
        LOCKED: begin
          if (match[off]) begin
            miss_nxt = 8'd0;
          end else if (miss >= MISS_LAST) begin
            miss_nxt  = MISS_MAX;
            state_nxt = HUNT;
          end else begin
            miss_nxt = miss + 8'd1;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge fast_clk_i) begin
    if (rst) begin
      state <= HUNT;
      off   <= 4'd0;
      hits  <= 4'd0;
      miss  <= 8'd0;
    end else begin
      state <= state_nxt;
      off   <= off_nxt;
      hits  <= hits_nxt;
      miss  <= miss_nxt;
    end
  end

  // The word emitted on a strobe uses the offset in force before that strobe.
  always_ff @(posedge fast_clk_i) begin
    if (rst) begin
      dat_o       <= '0;
      dat_valid_o <= 1'b0;
      comma_o     <= 1'b0;
    end else begin
      dat_valid_o <= strobe;
      if (strobe) begin
        dat_o   <= word_sel;
        comma_o <= match[off];
      end
    end
  end

  assign locked_o    = (state == LOCKED);
  assign align_off_o = off;
  assign fsm_state   = state;

endmodule
